// File: rtl/decode_issue.sv
// decode_issue: single-slot decode/issue stage with a 32 x n register file and pending-write scoreboard.
// Optional macro DECODE_BYPASS_EN forwards a same-edge writeback into the decoded operands.
module decode_issue #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_inst,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] rs1,
   output logic [n-1:0] rs2,
   output logic [31:0]  inst,
   input  logic         wb_en,
   input  logic [4:0]   wb_rd,
   input  logic [n-1:0] wb_data,
   output logic         busy
);

   typedef enum logic [1:0] {EMPTY, DEC, ISSUE} state_t;

   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   state_t       state, state_next;
   logic [n-1:0] regs [32];
   logic [31:0]  pending, pending_next;
   logic [4:0]   src1, src2, rd;
   logic         use1, use2;
   logic         capture, handshake, hazard;
   logic         wb_live, wb_hit1, wb_hit2;
   logic [n-1:0] opnd1, opnd2;

   // inst holds the captured instruction from capture through issue
   assign src1 = inst[19:15];
   assign src2 = inst[24:20];
   assign rd   = inst[11:7];
   assign use1 = (inst[6:0] == OP_REG) || (inst[6:0] == OP_IMM);
   assign use2 = (inst[6:0] == OP_REG);

   assign in_ready  = (state == EMPTY) || ((state == ISSUE) && out_ready);
   assign out_valid = (state == ISSUE);
   assign capture   = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign busy      = (state != EMPTY) || (|pending);
   assign wb_live   = wb_en && (wb_rd != 5'd0);

`ifdef DECODE_BYPASS_EN
   assign wb_hit1 = wb_live && (wb_rd == src1);
   assign wb_hit2 = wb_live && (wb_rd == src2);
`else
   assign wb_hit1 = 1'b0;
   assign wb_hit2 = 1'b0;
`endif

   assign hazard = (use1 && pending[src1] && !wb_hit1) ||
                   (use2 && pending[src2] && !wb_hit2);

   always_comb begin
      opnd1 = '0;
      opnd2 = '0;
      if (use1) opnd1 = wb_hit1 ? wb_data : regs[src1];
      if (use2) opnd2 = wb_hit2 ? wb_data : regs[src2];
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (capture) state_next = DEC;
         DEC:     if (!hazard) state_next = ISSUE;
         ISSUE:   if (out_ready) state_next = capture ? DEC : EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   // clear first so a same-edge set of the same bit takes priority
   always_comb begin
      pending_next = pending;
      if (wb_live) pending_next[wb_rd] = 1'b0;
      if (handshake && use1 && (rd != 5'd0)) pending_next[rd] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         inst    <= '0;
         rs1     <= '0;
         rs2     <= '0;
         pending <= '0;
      end else begin
         state   <= state_next;
         pending <= pending_next;
         if (capture) inst <= in_inst;
         if ((state == DEC) && !hazard) begin
            rs1 <= opnd1;
            rs2 <= opnd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_live) begin
         regs[wb_rd] <= wb_data;
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_decode_issue;

   localparam int N = 32;
`ifdef DECODE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [31:0] ADDI    = 32'h00328313;  // addi x6,x5,3
   localparam logic [31:0] ADD     = 32'h006303B3;  // add x7,x6,x6
   localparam logic [31:0] ADDI_X0 = 32'h00100013;  // addi x0,x0,1
   localparam logic [31:0] ADD3    = 32'h002081B3;  // add x3,x1,x2

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready, wb_en, busy;
   logic [31:0]  in_inst, inst;
   logic [N-1:0] rs1, rs2, wb_data;
   logic [4:0]   wb_rd;

   int total = 0;
   int bad   = 0;

   logic [N-1:0] m_regs [32];
   logic [31:0]  m_pend;
   bit           m_has, m_out;
   logic [31:0]  m_inst;
   logic [N-1:0] m_rs1, m_rs2;

   decode_issue #(.n(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2), .inst(inst),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic bit reads_a(input logic [31:0] i);
      return (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0010011);
   endfunction

   function automatic bit reads_b(input logic [31:0] i);
      return i[6:0] == 7'b0110011;
   endfunction

   function automatic bit fwd(input logic [4:0] s);
      return BYP && wb_en && (wb_rd == s) && (s != 5'd0);
   endfunction

   function automatic logic [N-1:0] operand(input logic [4:0] s);
      if (s == 5'd0) return '0;
      if (fwd(s)) return wb_data;
      return m_regs[s];
   endfunction

   // One clock edge of the reference: at most one instruction in flight, waiting or offered.
   task automatic model_step();
      bit          accept, take, leave, blocked;
      logic [4:0]  a, b, d;
      logic [N-1:0] va, vb;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_pend = '0; m_has = 0; m_out = 0; m_inst = '0; m_rs1 = '0; m_rs2 = '0;
         return;
      end
      accept = !m_has || (m_out && out_ready);
      take   = in_valid && accept;
      leave  = m_out && out_ready;
      a = m_inst[19:15]; b = m_inst[24:20]; d = m_inst[11:7];
      if (m_has && !m_out) begin
         blocked = (reads_a(m_inst) && m_pend[a] && !fwd(a)) ||
                   (reads_b(m_inst) && m_pend[b] && !fwd(b));
         if (!blocked) begin
            va = operand(a);
            vb = operand(b);
            m_rs1 = reads_a(m_inst) ? va : '0;
            m_rs2 = reads_b(m_inst) ? vb : '0;
            m_out = 1;
         end
      end
      if (wb_en && wb_rd != 5'd0) begin
         m_regs[wb_rd] = wb_data;
         m_pend[wb_rd] = 1'b0;
      end
      if (leave && reads_a(m_inst) && d != 5'd0) m_pend[d] = 1'b1;
      if (leave) begin
         m_has = take; m_out = 0;
         if (take) m_inst = in_inst;
      end else if (take) begin
         m_has = 1; m_inst = in_inst;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic r,
                        input logic we, input logic [4:0] wr, input logic [N-1:0] wd);
      in_valid = v; in_inst = i; out_ready = r; wb_en = we; wb_rd = wr; wb_data = wd;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, '0, 0, 0, '0, '0);
      tick(); tick();
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (rs1 !== '0) begin bad++; $display("FAIL reset_rs1: got %h want 0", rs1); end
      total++; if (rs2 !== '0) begin bad++; $display("FAIL reset_rs2: got %h want 0", rs2); end
      total++; if (inst !== '0) begin bad++; $display("FAIL reset_inst: got %h want 0", inst); end
   endtask

   task automatic test_addi();
      drive(0, '0, 0, 1, 5'd5, 32'h10); tick();
      drive(1, ADDI, 0, 0, '0, '0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_in_ready: got %b want 1", in_ready); end
      tick();
      drive(0, '0, 0, 0, '0, '0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_early_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL addi_busy: got %b want 1", busy); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", out_valid); end
      total++; if (rs1 !== 32'h10) begin bad++; $display("FAIL addi_rs1: got %h want 00000010", rs1); end
      total++; if (rs2 !== '0) begin bad++; $display("FAIL addi_rs2: got %h want 0", rs2); end
      total++; if (inst !== ADDI) begin bad++; $display("FAIL addi_inst: got %h want %h", inst, ADDI); end
   endtask

   task automatic test_hazard();
      drive(1, ADD, 1, 0, '0, '0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL haz_in_ready: got %b want 1", in_ready); end
      tick();
      drive(0, '0, 0, 0, '0, '0);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL haz_stall: got %b want 0", out_valid); end
      drive(0, '0, 0, 1, 5'd6, 32'h13);
      tick();
      drive(0, '0, 0, 0, '0, '0);
`ifndef DECODE_BYPASS_EN
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL haz_nobyp_wait: got %b want 0", out_valid); end
      tick();
`endif
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL haz_release: got %b want 1", out_valid); end
      total++; if (rs1 !== 32'h13) begin bad++; $display("FAIL haz_rs1: got %h want 00000013", rs1); end
      total++; if (rs2 !== 32'h13) begin bad++; $display("FAIL haz_rs2: got %h want 00000013", rs2); end
      drive(0, '0, 1, 0, '0, '0); tick();
      drive(0, '0, 0, 1, 5'd7, '0); tick();
      drive(0, '0, 0, 0, '0, '0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL haz_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_x0();
      drive(0, '0, 0, 1, 5'd0, 32'hFFFFFFFF); tick();
      drive(1, ADDI_X0, 0, 0, '0, '0); tick();
      drive(0, '0, 0, 0, '0, '0); tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL x0_valid: got %b want 1", out_valid); end
      total++; if (rs1 !== '0) begin bad++; $display("FAIL x0_rs1: got %h want 0", rs1); end
      drive(0, '0, 1, 0, '0, '0); tick();
      drive(0, '0, 0, 0, '0, '0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL x0_busy: got %b want 0", busy); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL x0_done: got %b want 0", out_valid); end
   endtask

   task automatic test_stall();
      drive(1, ADDI, 0, 0, '0, '0); tick();
      drive(0, '0, 0, 0, '0, '0); tick();
      for (int c = 0; c < 3; c++) begin
         drive(1, ADD3, 0, 0, '0, '0);
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", c, out_valid); end
         total++; if (rs1 !== 32'h10) begin bad++; $display("FAIL stall_rs1[%0d]: got %h want 00000010", c, rs1); end
         total++; if (inst !== ADDI) begin bad++; $display("FAIL stall_inst[%0d]: got %h want %h", c, inst, ADDI); end
         tick();
      end
      drive(1, ADD3, 1, 0, '0, '0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
      tick();
      drive(0, '0, 0, 0, '0, '0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_dec: got %b want 0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_next_valid: got %b want 1", out_valid); end
      total++; if (inst !== ADD3) begin bad++; $display("FAIL stall_next_inst: got %h want %h", inst, ADD3); end
      drive(0, '0, 1, 0, '0, '0); tick();
      drive(0, '0, 0, 1, 5'd6, '0); tick();
      drive(0, '0, 0, 1, 5'd3, '0); tick();
      drive(0, '0, 0, 0, '0, '0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_set_wins();
      drive(1, ADDI, 0, 0, '0, '0); tick();
      drive(0, '0, 0, 0, '0, '0); tick();
      drive(0, '0, 1, 1, 5'd6, 32'h99); tick();
      drive(0, '0, 0, 0, '0, '0);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL setwin_busy: got %b want 1", busy); end
      drive(1, ADD, 0, 0, '0, '0); tick();
      drive(0, '0, 0, 0, '0, '0); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL setwin_hold1: got %b want 0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL setwin_hold2: got %b want 0", out_valid); end
      drive(0, '0, 0, 1, 5'd6, 32'h55); tick();
      drive(0, '0, 0, 0, '0, '0);
`ifndef DECODE_BYPASS_EN
      tick();
`endif
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL setwin_release: got %b want 1", out_valid); end
      total++; if (rs1 !== 32'h55) begin bad++; $display("FAIL setwin_rs1: got %h want 00000055", rs1); end
      drive(0, '0, 1, 0, '0, '0); tick();
      drive(0, '0, 0, 1, 5'd7, '0); tick();
      drive(0, '0, 0, 0, '0, '0);
   endtask

   task automatic test_reset_in_dec();
      drive(0, '0, 0, 1, 5'd5, 32'h77); tick();
      drive(1, ADDI, 0, 0, '0, '0); tick();
      rst = 1'b1;
      drive(0, '0, 0, 1, 5'd5, 32'h33); tick();
      rst = 1'b0;
      drive(0, '0, 0, 0, '0, '0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstdec_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstdec_busy: got %b want 0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstdec_ready: got %b want 1", in_ready); end
      drive(1, ADDI, 0, 0, '0, '0); tick();
      drive(0, '0, 0, 0, '0, '0); tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstdec_reissue: got %b want 1", out_valid); end
      total++; if (rs1 !== '0) begin bad++; $display("FAIL rstdec_x5: got %h want 0", rs1); end
   endtask

   task automatic test_random();
      logic [31:0]  ri;
      logic [6:0]   op;
      int unsigned  k;
      rst = 1'b1;
      drive(0, '0, 0, 0, '0, '0); tick();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         k = $urandom_range(0, 3);
         op = (k == 0) ? 7'b0110011 : (k == 1) ? 7'b0010011 : (k == 2) ? 7'h03 : 7'($urandom);
         ri = $urandom;
         ri[6:0]   = op;
         ri[11:7]  = 5'($urandom_range(0, 7));
         ri[19:15] = 5'($urandom_range(0, 7));
         ri[24:20] = 5'($urandom_range(0, 7));
         rst = ($urandom_range(0, 199) == 0);
         drive(1'($urandom_range(0, 1)), ri, ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), N'($urandom));
         total++; if (in_ready !== (!m_has || (m_out && out_ready))) begin
            bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, (!m_has || (m_out && out_ready)));
         end
         total++; if (out_valid !== m_out) begin
            bad++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_valid, m_out);
         end
         total++; if (busy !== (m_has || (|m_pend))) begin
            bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, (m_has || (|m_pend)));
         end
         if (m_out) begin
            total++; if (rs1 !== m_rs1) begin bad++; $display("FAIL rnd_rs1[%0d]: got %h want %h", c, rs1, m_rs1); end
            total++; if (rs2 !== m_rs2) begin bad++; $display("FAIL rnd_rs2[%0d]: got %h want %h", c, rs2, m_rs2); end
            total++; if (inst !== m_inst) begin bad++; $display("FAIL rnd_inst[%0d]: got %h want %h", c, inst, m_inst); end
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 0; in_inst = '0; out_ready = 0; wb_en = 0; wb_rd = '0; wb_data = '0;
      @(negedge clk);
      test_reset();
      test_addi();
      test_hazard();
      test_x0();
      test_stall();
      test_set_wins();
      test_reset_in_dec();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
